intersection_controller: RTL

//  Sequences two stoplight heads (north-south main road, east-west side road) plus a pedestrian

---
 rtl/stoplight_pkg.sv | 21 ++
 rtl/tick_gen.sv | 27 ++
 rtl/intersection_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stoplight_pkg.sv
// rtl/stoplight_pkg.sv - shared state codes and lamp colours for the intersection controller
package stoplight_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT      = 3'd0;
  localparam state_t ST_NS_GREEN  = 3'd1;
  localparam state_t ST_NS_YELLOW = 3'd2;
  localparam state_t ST_ALLRED_A  = 3'd3;
  localparam state_t ST_EW_GREEN  = 3'd4;
  localparam state_t ST_EW_YELLOW = 3'd5;
  localparam state_t ST_ALLRED_B  = 3'd6;
  localparam state_t ST_WALK      = 3'd7;

  // Lamp pins are {R,G,B}; yellow is red+green on an RGB LED.
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_OFF    = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every BoardFreq cycles
module tick_gen #(
  parameter int BoardFreq = 100_000_000
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int W = (BoardFreq > 1) ? $clog2(BoardFreq) : 1;
  localparam logic [W-1:0] LAST = W'(BoardFreq - 1);

  logic [W-1:0] divider;

  assign tick = (divider == LAST);

  // Count 0..BoardFreq-1 and wrap; tick is high on the last count.
  always_ff @(posedge Clock) begin
    if (Reset)
      divider <= '0;
    else if (tick)
      divider <= '0;
    else
      divider <= divider + 1'b1;
  end

endmodule

// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - two-head stoplight plus WALK lamp, Moore FSM stepped by a tick
module intersection_controller
  import stoplight_pkg::*;
#(
  parameter int BoardFreq = 100_000_000,
  parameter int GreenNs   = 30,
  parameter int GreenEw   = 20,
  parameter int YellowT   = 3,
  parameter int AllRedT   = 2,
  parameter int WalkT     = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] rgb_ns,
  output logic [2:0] rgb_ew,
  output logic       walk,
  output logic [4:0] count_led
);

  localparam bit DUR_OK = (GreenNs >= 1) && (GreenNs <= 31) && (GreenEw >= 1) && (GreenEw <= 31)
                       && (YellowT >= 1) && (YellowT <= 31) && (AllRedT >= 1) && (AllRedT <= 31)
                       && (WalkT >= 1) && (WalkT <= 31);

  if (!DUR_OK) begin : g_bad_duration
    $error("intersection_controller: every phase duration must be 1..31 ticks");
  end
  if (BoardFreq < 1) begin : g_bad_freq
    $error("intersection_controller: BoardFreq must be at least 1");
  end

  logic       tick;
  state_t     state;
  state_t     state_next;
  logic [4:0] count;
  logic [4:0] dur_last;
  logic       phase_done;
  logic       ew_pend;
  logic       ped_pend;
  logic       enter_ew;
  logic       enter_walk;

  tick_gen #(.BoardFreq(BoardFreq)) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (tick)
  );

  // Last counter value of the current state before it hands over.
  always_comb begin
    dur_last = 5'(AllRedT - 1);
    case (state)
      ST_INIT:      dur_last = 5'(AllRedT - 1);
      ST_NS_GREEN:  dur_last = 5'(GreenNs - 1);
      ST_NS_YELLOW: dur_last = 5'(YellowT - 1);
      ST_ALLRED_A:  dur_last = 5'(AllRedT - 1);
      ST_EW_GREEN:  dur_last = 5'(GreenEw - 1);
      ST_EW_YELLOW: dur_last = 5'(YellowT - 1);
      ST_ALLRED_B:  dur_last = 5'(AllRedT - 1);
      ST_WALK:      dur_last = 5'(WalkT - 1);
      default:      dur_last = 5'(AllRedT - 1);
    endcase
  end

  assign phase_done = tick && (count == dur_last);

  // Successor state; side-road and walk phases are only entered on a pending request.
  always_comb begin
    state_next = ST_INIT;
    case (state)
      ST_INIT:      state_next = ST_NS_GREEN;
      ST_NS_GREEN:  state_next = ST_NS_YELLOW;
      ST_NS_YELLOW: state_next = ST_ALLRED_A;
      ST_ALLRED_A:  state_next = ew_pend ? ST_EW_GREEN : (ped_pend ? ST_WALK : ST_NS_GREEN);
      ST_EW_GREEN:  state_next = ST_EW_YELLOW;
      ST_EW_YELLOW: state_next = ST_ALLRED_B;
      ST_ALLRED_B:  state_next = ped_pend ? ST_WALK : ST_NS_GREEN;
      ST_WALK:      state_next = ST_NS_GREEN;
      default:      state_next = ST_INIT;
    endcase
  end

  assign enter_ew   = phase_done && (state_next == ST_EW_GREEN);
  assign enter_walk = phase_done && (state_next == ST_WALK);

  // State register and seconds-in-state counter, both advanced only on ticks.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_INIT;
      count <= '0;
    end else if (phase_done) begin
      state <= state_next;
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // Request latches; a new request arriving on the serving edge is kept for the next cycle round.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ew_pend  <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      ew_pend  <= car_ew  | (ew_pend  & ~enter_ew);
      ped_pend <= ped_req | (ped_pend & ~enter_walk);
    end
  end

  // Moore output decode; anything not explicitly green/yellow/walk shows all red.
  always_comb begin
    rgb_ns = RGB_RED;
    rgb_ew = RGB_RED;
    walk   = 1'b0;
    case (state)
      ST_NS_GREEN:  rgb_ns = RGB_GREEN;
      ST_NS_YELLOW: rgb_ns = RGB_YELLOW;
      ST_EW_GREEN:  rgb_ew = RGB_GREEN;
      ST_EW_YELLOW: rgb_ew = RGB_YELLOW;
      ST_WALK:      walk   = 1'b1;
      default: begin
        rgb_ns = RGB_RED;
        rgb_ew = RGB_RED;
        walk   = 1'b0;
      end
    endcase
  end

  assign count_led = count;

endmodule
